uart_tx_fifo: RTL and testbench

Transmit buffer between the CPU memory bus and the `uart` block. The CPU pushes bytes into a DEPTH-entry FIFO without waiting, and a drain state machine forwards them to the UART. The drain FSM acts as a bus master on the UART's slave port: it polls the UART STATUS register (bit0 = tx ready) and then writes the UART DATA register (byte lane 0). Peripheral decode routes CPU TX traffic here and routes the UART master port straight to `uart`.

---
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Single-cycle memory-mapped bus used on both the CPU side and the uart side of uart_tx_fifo.
interface uart_tx_fifo_if;
    logic [31:0] address;
    logic        sel;
    logic        read;
    logic [31:0] read_value;
    logic [3:0]  write_mask;
    logic [31:0] write_value;
    logic        ready;

    modport master (
        output address, sel, read, write_mask, write_value,
        input  read_value, ready
    );

    modport slave (
        input  address, sel, read, write_mask, write_value,
        output read_value, ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// CPU transmit FIFO with a drain FSM that polls the uart STATUS register and writes its DATA register.
// Define UART_TX_FIFO_IRQ_EN to add the tx_int output and the CTRL.irq_en bit.
module uart_tx_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] UART_BASE = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  cpu,
    uart_tx_fifo_if.master uart
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    output logic           tx_int
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, POLL, WRITE} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          overflow, drop_pop;
    logic          m_sel, m_read;
    logic [31:0]   m_address, m_write_value;
    logic [3:0]    m_write_mask;
    logic [1:0]    reg_sel;
    logic          cpu_wr, empty, full, push, do_push, flush, ovf_clr, pop;
    logic [31:0]   status, ctrl_rd, rd_value;

    assign reg_sel = cpu.address[3:2];
    assign cpu_wr  = cpu.sel && !cpu.read && cpu.write_mask[0];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push    = cpu_wr && (reg_sel == 2'd0);
    assign flush   = cpu_wr && (reg_sel == 2'd2) && cpu.write_value[0];
    assign ovf_clr = cpu_wr && (reg_sel == 2'd1) && cpu.write_value[2];
    assign do_push = push && !full && !flush;
    assign pop     = (state == WRITE) && uart.ready && !drop_pop && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                case ({do_push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= cpu.write_value[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            m_sel         <= 1'b0;
            m_read        <= 1'b0;
            m_address     <= '0;
            m_write_mask  <= '0;
            m_write_value <= '0;
            drop_pop      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty && !flush) begin
                    state     <= POLL;
                    m_sel     <= 1'b1;
                    m_read    <= 1'b1;
                    m_address <= UART_BASE + 32'd4;
                end
                POLL: if (flush) begin
                    state     <= IDLE;
                    m_sel     <= 1'b0;
                    m_read    <= 1'b0;
                    m_address <= '0;
                end else if (uart.ready && uart.read_value[0]) begin
                    state         <= WRITE;
                    m_read        <= 1'b0;
                    m_address     <= UART_BASE + 32'd8;
                    m_write_mask  <= 4'b0001;
                    m_write_value <= {24'b0, mem[rd_ptr]};
                end
                WRITE: if (uart.ready) begin
                    state         <= IDLE;
                    m_sel         <= 1'b0;
                    m_address     <= '0;
                    m_write_mask  <= '0;
                    m_write_value <= '0;
                    drop_pop      <= 1'b0;
                end else if (flush) begin
                    // A flush landing on a stalled WRITE must also cancel the pop that later completes it.
                    drop_pop <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    m_sel         <= 1'b0;
                    m_read        <= 1'b0;
                    m_address     <= '0;
                    m_write_mask  <= '0;
                    m_write_value <= '0;
                    drop_pop      <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            tx_int <= 1'b0;
        end else begin
            if (cpu_wr && (reg_sel == 2'd2)) irq_en <= cpu.write_value[1];
            tx_int <= irq_en && empty && (state == IDLE);
        end
    end

    assign ctrl_rd = {30'b0, irq_en, 1'b0};
`else
    assign ctrl_rd = '0;
`endif

    assign status = {{(23 - AW){1'b0}}, count, 5'b0, overflow, full, empty};

    always_comb begin
        rd_value = '0;
        if (cpu.sel) begin
            case (reg_sel)
                2'd1:    rd_value = status;
                2'd2:    rd_value = ctrl_rd;
                default: rd_value = '0;
            endcase
        end
    end

    assign cpu.read_value   = rd_value;
    assign cpu.ready        = cpu.sel;
    assign uart.sel         = m_sel;
    assign uart.read        = m_read;
    assign uart.address     = m_address;
    assign uart.write_mask  = m_write_mask;
    assign uart.write_value = m_write_value;

    logic unused_bits;
    assign unused_bits = ^{cpu.address[31:4], cpu.address[1:0], cpu.write_value[31:8],
                           cpu.write_mask[3:1], uart.read_value[31:1]};
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue model of the FIFO plus a per-cycle bus checker.
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rdy = 1'b1;
    logic        uart_tx_ok = 1'b1;
    int unsigned cyc = 0;
    int unsigned passes = 0;
    int unsigned total = 0;

    logic [7:0]  model_q[$];
    logic        model_ovf = 1'b0;
    logic [7:0]  deliv_byte[$];
    int unsigned deliv_edge[$];
    logic [7:0]  exp3 [3] = '{8'h11, 8'h22, 8'h33};
`ifdef UART_TX_FIFO_IRQ_EN
    logic        tx_int;
`endif

    uart_tx_fifo_if cpu_bus();
    uart_tx_fifo_if uart_bus();

    assign uart_bus.ready      = uart_rdy;
    assign uart_bus.read_value = {31'b0, uart_tx_ok};

    uart_tx_fifo #(.DEPTH(DEPTH), .UART_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_bus),
        .uart  (uart_bus)
`ifdef UART_TX_FIFO_IRQ_EN
        ,
        .tx_int(tx_int)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 32'h%08h, want 32'h%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_status();
        int unsigned n = model_q.size();
        return (n << 8) | (model_ovf ? 32'd4 : 32'd0) | ((n == DEPTH) ? 32'd2 : 32'd0)
               | ((n == 0) ? 32'd1 : 32'd0);
    endfunction

    // Bus checker: the uart port must be idle, a STATUS poll, or a DATA write of the model's head byte.
    always @(negedge clk) begin
        if (!cpu_bus.sel) chk("cpu_rdata_unselected", cpu_bus.read_value, '0);
        chk("cpu_ready", {31'b0, cpu_bus.ready}, {31'b0, cpu_bus.sel});
        if (!uart_bus.sel) begin
            chk("uart_idle_addr", uart_bus.address, '0);
            chk("uart_idle_ctl", {27'b0, uart_bus.read, uart_bus.write_mask}, '0);
            chk("uart_idle_value", uart_bus.write_value, '0);
        end else if (uart_bus.read) begin
            chk("poll_addr", uart_bus.address, BASE + 32'd4);
            chk("poll_mask", {28'b0, uart_bus.write_mask}, '0);
        end else begin
            chk("write_addr", uart_bus.address, BASE + 32'd8);
            chk("write_mask", {28'b0, uart_bus.write_mask}, 32'h1);
            if (uart_rdy) begin
                if (model_q.size() == 0) begin
                    total++;
                    $display("FAIL write_unexpected: got 32'h%08h, want no write (cycle %0d)",
                             uart_bus.write_value, cyc);
                end else begin
                    chk("write_data", uart_bus.write_value, {24'b0, model_q.pop_front()});
                end
                deliv_byte.push_back(uart_bus.write_value[7:0]);
                deliv_edge.push_back(cyc + 1);
            end
        end
    end

    task automatic idle_cpu();
        cpu_bus.sel         = 1'b0;
        cpu_bus.read        = 1'b0;
        cpu_bus.address     = '0;
        cpu_bus.write_mask  = '0;
        cpu_bus.write_value = '0;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, output int unsigned edge_n);
        cpu_bus.sel         = 1'b1;
        cpu_bus.read        = 1'b0;
        cpu_bus.address     = 32'h0;
        cpu_bus.write_mask  = 4'h1;
        cpu_bus.write_value = {24'h5A5A5A, b};
        edge_n = cyc + 1;
        if (model_q.size() == DEPTH) model_ovf = 1'b1;
        else model_q.push_back(b);
        wait_cycles(1);
        idle_cpu();
    endtask

    task automatic cpu_write(input logic [1:0] r, input logic [31:0] v);
        cpu_bus.sel         = 1'b1;
        cpu_bus.read        = 1'b0;
        cpu_bus.address     = {28'b0, r, 2'b00};
        cpu_bus.write_mask  = 4'hF;
        cpu_bus.write_value = v;
        wait_cycles(1);
        idle_cpu();
    endtask

    task automatic cpu_read(input logic [1:0] r, output logic [31:0] v);
        cpu_bus.sel     = 1'b1;
        cpu_bus.read    = 1'b1;
        cpu_bus.address = {28'b0, r, 2'b00};
        #2;
        v = cpu_bus.read_value;
        wait_cycles(1);
        idle_cpu();
    endtask

    task automatic check_status(input string name, input logic [31:0] lit);
        logic [31:0] v;
        cpu_read(2'd1, v);
        chk({name, "_model"}, v, model_status());
        chk(name, v, lit);
    endtask

    task automatic clear_log();
        deliv_byte.delete();
        deliv_edge.delete();
    endtask

    initial begin
        int unsigned n;
        int unsigned n2;
        logic [31:0] v;

        idle_cpu();
        wait_cycles(3);
        chk("reset_uart_sel", {31'b0, uart_bus.sel}, '0);
        reset = 1'b1;
        wait_cycles(2);
        check_status("reset_status", 32'h1);
        cpu_read(2'd0, v);
        chk("data_reads_zero", v, '0);
        cpu_read(2'd3, v);
        chk("reg3_reads_zero", v, '0);

        // Single byte: accepted by the uart three edges after the push edge.
        clear_log();
        push(8'h41, n);
        wait_cycles(6);
        chk("single_sent", deliv_byte.size(), 1);
        if (deliv_byte.size() == 1) begin
            chk("single_byte", {24'b0, deliv_byte[0]}, 32'h41);
            chk("single_edge", deliv_edge[0], n + 3);
        end
        check_status("single_status", 32'h1);

        // uart busy: FSM parks in POLL, then drains in order at 3-cycle spacing.
        clear_log();
        uart_tx_ok = 1'b0;
        push(8'h11, n);
        push(8'h22, n);
        push(8'h33, n);
        wait_cycles(20);
        chk("stall_in_poll", {30'b0, uart_bus.sel, uart_bus.read}, 32'h3);
        check_status("stall_status", 32'h0000_0300);
        chk("stall_none_sent", deliv_byte.size(), 0);
        uart_tx_ok = 1'b1;
        wait_cycles(15);
        chk("stall_sent", deliv_byte.size(), 3);
        if (deliv_byte.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("stall_order", {24'b0, deliv_byte[i]}, {24'b0, exp3[i]});
            for (int i = 1; i < 3; i++) chk("stall_spacing", deliv_edge[i] - deliv_edge[i-1], 3);
        end
        check_status("stall_drained", 32'h1);

        // DEPTH+1 pushes while stalled: the last one is dropped and flags overflow.
        clear_log();
        uart_tx_ok = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(32'h50 + i), n);
        check_status("ovf_status", 32'h0000_1006);
        cpu_write(2'd1, 32'h4);
        model_ovf = 1'b0;
        check_status("ovf_cleared", 32'h0000_1002);
        uart_tx_ok = 1'b1;
        wait_cycles(60);
        chk("ovf_sent", deliv_byte.size(), 16);
        if (deliv_byte.size() == 16)
            for (int i = 0; i < 16; i++) chk("ovf_order", {24'b0, deliv_byte[i]}, 32'h50 + i);
        check_status("ovf_drained", 32'h1);

        // Flush while the 0xAA write is on the bus: 0xAA completes, 0xBB is discarded.
        clear_log();
        push(8'hAA, n);
        push(8'hBB, n2);
        wait_cycles(1);
        chk("flush_write_on_bus", {30'b0, uart_bus.sel, uart_bus.read}, 32'h2);
        cpu_write(2'd2, 32'h1);
        model_q.delete();
        wait_cycles(10);
        chk("flush_sent", deliv_byte.size(), 1);
        if (deliv_byte.size() == 1) begin
            chk("flush_byte", {24'b0, deliv_byte[0]}, 32'hAA);
            chk("flush_edge", deliv_edge[0], n + 3);
        end
        check_status("flush_status", 32'h1);

`ifdef UART_TX_FIFO_IRQ_EN
        clear_log();
        cpu_write(2'd2, 32'h2);
        cpu_read(2'd2, v);
        chk("ctrl_irq_en", v, 32'h2);
        chk("irq_idle_high", {31'b0, tx_int}, 32'h1);
        push(8'h5C, n);
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            chk("irq_pending_low", {31'b0, tx_int}, '0);
        end
        wait_cycles(1);
        chk("irq_done_high", {31'b0, tx_int}, 32'h1);
        chk("irq_sent", deliv_byte.size(), 1);
        cpu_write(2'd2, 32'h0);
`else
        cpu_write(2'd2, 32'h2);
        cpu_read(2'd2, v);
        chk("ctrl_reads_zero", v, '0);
`endif

        // Async reset while a WRITE is held on the bus.
        clear_log();
        push(8'h77, n);
        wait_cycles(2);
        uart_rdy = 1'b0;
        wait_cycles(2);
        chk("rst_held_write", {30'b0, uart_bus.sel, uart_bus.read}, 32'h2);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_addr", uart_bus.address, '0);
        chk("rst_async_ctl", {27'b0, uart_bus.sel, uart_bus.read, uart_bus.write_mask}, '0);
        chk("rst_async_value", uart_bus.write_value, '0);
        model_q.delete();
        model_ovf = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        uart_rdy = 1'b1;
        wait_cycles(3);
        check_status("rst_status", 32'h1);
        chk("rst_nothing_sent", deliv_byte.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
